// File: rtl/softmax_online.sv
// Online (streaming) softmax front end: per-lane running max, base-2 exponent and running denominator.
// Optional macro SOFTMAX_DENOM_SAT_EN clamps the denominator and raises o_sat instead of wrapping.

module softmax_online_lane #(
  parameter int IN_W   = 40,
  parameter int FRAC_W = 10,
  parameter int Y_W    = 8,
  parameter int DEN_W  = 12
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          accept,
  input  logic                          first,
  input  logic [IN_W-1:0]               score,
  output logic [Y_W-1:0]                y,
  output logic signed [IN_W-FRAC_W-1:0] runmax,
  output logic [DEN_W-1:0]              denom,
  output logic                          sat
);
  localparam int XW = IN_W - FRAC_W;
  localparam logic [IN_W:0]    HALF  = (IN_W+1)'(1) << (FRAC_W-1);
  localparam logic [Y_W-1:0]   ONE   = {1'b1, {(Y_W-1){1'b0}}};
  localparam logic [XW:0]      Y_LIM = (XW+1)'(Y_W);
  localparam logic [XW:0]      D_LIM = (XW+1)'(DEN_W);

  logic signed [IN_W:0] s_ext, rnd, q;
  logic signed [XW-1:0] x;
  logic                 x_ovf;
  logic signed [XW:0]   diff;
  logic [XW:0]          mag;
  logic                 rise;
  logic [Y_W-1:0]       y_nxt;
  logic [DEN_W-1:0]     den_base, den_nxt;

  // Round half away from zero: negative values get half-1 before the floor shift.
  assign s_ext = {score[IN_W-1], score};
  assign rnd   = s_ext + $signed(HALF) - $signed({{IN_W{1'b0}}, score[IN_W-1]});
  assign q     = rnd >>> FRAC_W;
  assign x_ovf = !q[IN_W] && |q[IN_W-1:XW-1];
  assign x     = x_ovf ? {1'b0, {(XW-1){1'b1}}} : q[XW-1:0];

  assign diff = {x[XW-1], x} - {runmax[XW-1], runmax};
  assign mag  = diff[XW] ? $unsigned(-diff) : $unsigned(diff);
  assign rise = !diff[XW] && |diff;

  always_comb begin
    y_nxt    = ONE;
    den_base = '0;
    if (!first) begin
      if (rise) begin
        den_base = (mag >= D_LIM) ? '0 : denom >> mag;
      end else begin
        y_nxt    = (mag >= Y_LIM) ? '0 : ONE >> mag;
        den_base = denom;
      end
    end
  end

`ifdef SOFTMAX_DENOM_SAT_EN
  logic [DEN_W:0] sum;
  logic           sat_q;
  assign sum     = {1'b0, den_base} + (DEN_W+1)'(y_nxt);
  assign den_nxt = sum[DEN_W] ? '1 : sum[DEN_W-1:0];
  assign sat     = sat_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    sat_q <= 1'b0;
    else if (accept) sat_q <= (!first && sat_q) || sum[DEN_W];
  end
`else
  assign den_nxt = den_base + DEN_W'(y_nxt);
  assign sat     = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      y      <= '0;
      runmax <= '0;
      denom  <= '0;
    end else if (accept) begin
      y      <= y_nxt;
      denom  <= den_nxt;
      if (first || rise) runmax <= x;
    end
  end
endmodule

module softmax_online #(
  parameter int LANES  = 16,
  parameter int IN_W   = 40,
  parameter int FRAC_W = 10,
  parameter int Y_W    = 8,
  parameter int DEN_W  = 12
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic                              i_last,
  input  logic [LANES*IN_W-1:0]             i_data,
  output logic [LANES*Y_W-1:0]              o_y,
  output logic                              o_y_valid,
  input  logic                              i_y_ready,
  output logic [LANES*(IN_W-FRAC_W)-1:0]    o_runmax,
  output logic [LANES*DEN_W-1:0]            o_denom,
  output logic                              o_denom_valid,
  output logic                              o_sat
);
  localparam int XW = IN_W - FRAC_W;

  typedef enum logic {S_IDLE, S_ACC} state_t;
  state_t state, state_nxt;

  logic             accept;
  logic [LANES-1:0] sat_l;

  assign o_ready = !o_y_valid || i_y_ready;
  assign accept  = i_valid && o_ready;
  assign o_sat   = |sat_l;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = i_last ? S_IDLE : S_ACC;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_y_valid     <= 1'b0;
      o_denom_valid <= 1'b0;
    end else begin
      o_denom_valid <= accept && i_last;
      if (accept)         o_y_valid <= 1'b1;
      else if (i_y_ready) o_y_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    softmax_online_lane #(
      .IN_W(IN_W), .FRAC_W(FRAC_W), .Y_W(Y_W), .DEN_W(DEN_W)
    ) u_lane (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .accept (accept),
      .first  (state == S_IDLE),
      .score  (i_data[k*IN_W +: IN_W]),
      .y      (o_y[k*Y_W +: Y_W]),
      .runmax (o_runmax[k*XW +: XW]),
      .denom  (o_denom[k*DEN_W +: DEN_W]),
      .sat    (sat_l[k])
    );
  end
endmodule

// File: tb/tb_softmax_online.sv
// Directed bench for softmax_online: rows, rounding, backpressure, denominator overflow, mid-row reset.

module tb_softmax_online;
  localparam int LANES = 16, IN_W = 40, FRAC_W = 10, Y_W = 8, DEN_W = 12;
  localparam int XW = IN_W - FRAC_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   valid, ready, last, y_valid, y_ready, denom_valid, sat;
  logic [LANES*IN_W-1:0]  data;
  logic [LANES*Y_W-1:0]   y;
  logic [LANES*XW-1:0]    runmax;
  logic [LANES*DEN_W-1:0] denom;

  int checks = 0, errors = 0, dv_cnt = 0, dv_base;

  always #5 clk = ~clk;

  softmax_online #(.LANES(LANES), .IN_W(IN_W), .FRAC_W(FRAC_W), .Y_W(Y_W), .DEN_W(DEN_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready), .i_last(last),
    .i_data(data), .o_y(y), .o_y_valid(y_valid), .i_y_ready(y_ready),
    .o_runmax(runmax), .o_denom(denom), .o_denom_valid(denom_valid), .o_sat(sat)
  );

  always @(posedge clk) if (denom_valid) dv_cnt <= dv_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint rm(input int lane);
    logic signed [XW-1:0] r;
    r = runmax[lane*XW +: XW];
    return longint'(r);
  endfunction

  // One beat, same score on every lane; returns just after the accepting edge.
  task automatic beat(input string tag, input logic signed [IN_W-1:0] s, input logic l,
                      input logic [Y_W-1:0] exp_y);
    int n = 0;
    @(negedge clk);
    valid = 1'b1;
    last  = l;
    for (int k = 0; k < LANES; k++) data[k*IN_W +: IN_W] = s;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk({tag, "_ready_timeout"}, 64'(ready), 64'd1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    last  = 1'b0;
    chk({tag, "_y0"}, 64'(y[Y_W-1:0]), 64'(exp_y));
    chk({tag, "_yN"}, 64'(y[(LANES-1)*Y_W +: Y_W]), 64'(exp_y));
    chk({tag, "_yv"}, 64'(y_valid), 64'd1);
  endtask

  task automatic end_row(input string tag, input logic [DEN_W-1:0] exp_den, input longint exp_rm,
                         input logic exp_sat);
    chk({tag, "_dv"}, 64'(denom_valid), 64'd1);
    chk({tag, "_den"}, 64'(denom[DEN_W-1:0]), 64'(exp_den));
    chk({tag, "_denN"}, 64'(denom[(LANES-1)*DEN_W +: DEN_W]), 64'(exp_den));
    chk({tag, "_rm"}, 64'(rm(0)), 64'(exp_rm));
    chk({tag, "_sat"}, 64'(sat), 64'(exp_sat));
    @(posedge clk);
    #1;
    chk({tag, "_dv_off"}, 64'(denom_valid), 64'd0);
    chk({tag, "_den_hold"}, 64'(denom[DEN_W-1:0]), 64'(exp_den));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_y"}, 64'(y[Y_W-1:0]), 64'd0);
    chk({tag, "_yv"}, 64'(y_valid), 64'd0);
    chk({tag, "_rm"}, 64'(rm(0)), 64'd0);
    chk({tag, "_den"}, 64'(denom[DEN_W-1:0]), 64'd0);
    chk({tag, "_dv"}, 64'(denom_valid), 64'd0);
    chk({tag, "_sat"}, 64'(sat), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; last = 1'b0; y_ready = 1'b1; data = '0;
    #12;
    chk_reset("rst");
    @(negedge clk) rst_n = 1'b1;

    // 3-beat row with a falling score
    dv_base = dv_cnt;
    beat("r1b0", 40'sh800, 1'b0, 8'h80);
    beat("r1b1", 40'sh400, 1'b0, 8'h40);
    beat("r1b2", 40'sh000, 1'b1, 8'h20);
    end_row("r1", 12'h0E0, 2, 1'b0);
    chk("r1_dv_once", 64'(dv_cnt - dv_base), 64'd1);

    // rising max rescales the denominator
    beat("r2b0", 40'sh000, 1'b0, 8'h80);
    beat("r2b1", 40'shC00, 1'b1, 8'h80);
    end_row("r2", 12'h090, 3, 1'b0);

    // rounding, half away from zero
    beat("rnd_p", 40'sh600, 1'b1, 8'h80);
    end_row("rnd_p", 12'h080, 2, 1'b0);
    beat("rnd_n", -40'sh600, 1'b1, 8'h80);
    end_row("rnd_n", 12'h080, -2, 1'b0);
    beat("rnd_h", -40'sh200, 1'b1, 8'h80);
    end_row("rnd_h", 12'h080, -1, 1'b0);
    beat("rnd_lo", 40'sh1FF, 1'b1, 8'h80);
    end_row("rnd_lo", 12'h080, 0, 1'b0);

    // far-below score shifts y to zero
    beat("far0", 40'sh2800, 1'b0, 8'h80);
    beat("far1", 40'sh000, 1'b1, 8'h00);
    end_row("far", 12'h080, 10, 1'b0);

    // backpressure: consumer stalls for 3 cycles while the next beat waits
    @(negedge clk) y_ready = 1'b1;
    @(negedge clk) y_ready = 1'b0;
    beat("bp0", 40'sh800, 1'b0, 8'h80);
    @(negedge clk);
    valid = 1'b1;
    for (int k = 0; k < LANES; k++) data[k*IN_W +: IN_W] = 40'sh400;
    for (int c = 0; c < 3; c++) begin
      chk("bp_ready_low", 64'(ready), 64'd0);
      chk("bp_y_hold", 64'(y[Y_W-1:0]), 64'h80);
      chk("bp_yv_hold", 64'(y_valid), 64'd1);
      @(negedge clk);
    end
    y_ready = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("bp1_y", 64'(y[Y_W-1:0]), 64'h40);
    beat("bp2", 40'sh000, 1'b1, 8'h20);
    end_row("bp", 12'h0E0, 2, 1'b0);

    // consumer drains: o_y_valid drops with no new beat
    @(negedge clk);
    chk("drain_yv", 64'(y_valid), 64'd0);

    // 40 equal beats overflow a 12-bit denominator
    for (int i = 0; i < 40; i++) beat("sat", 40'sh000, (i == 39), 8'h80);
`ifdef SOFTMAX_DENOM_SAT_EN
    end_row("sat", 12'hFFF, 0, 1'b1);
`else
    end_row("sat", 12'h400, 0, 1'b0);
`endif
    beat("sat_clr", 40'sh400, 1'b1, 8'h80);
    end_row("sat_clr", 12'h080, 1, 1'b0);

    // reset mid-row, then a one-beat row
    beat("mr0", 40'sh800, 1'b0, 8'h80);
    beat("mr1", 40'sh400, 1'b0, 8'h40);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk_reset("mrst");
    @(negedge clk) rst_n = 1'b1;
    dv_base = dv_cnt;
    beat("mr2", 40'shC00, 1'b1, 8'h80);
    end_row("mr", 12'h080, 3, 1'b0);
    chk("mr_dv_once", 64'(dv_cnt - dv_base), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
